// File: rtl/dsk_arb.sv
// Two-master round-robin arbiter in front of the disk controller bus port.
// Optional ownership lock is enabled by defining DSK_ARB_LOCK_EN.
module dsk_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_en,
  input  logic        m0_wr,
  input  logic [19:2] m0_addr,
  input  logic [31:0] m0_data_in,
  input  logic        m0_lock,
  output logic [31:0] m0_data_out,
  output logic        m0_wt,
  output logic        m0_irq,
  input  logic        m1_en,
  input  logic        m1_wr,
  input  logic [19:2] m1_addr,
  input  logic [31:0] m1_data_in,
  input  logic        m1_lock,
  output logic [31:0] m1_data_out,
  output logic        m1_wt,
  output logic        m1_irq,
  output logic        dsk_en,
  output logic        dsk_wr,
  output logic [19:2] dsk_addr,
  output logic [31:0] dsk_data_in,
  input  logic [31:0] dsk_data_out,
  input  logic        dsk_wt,
  input  logic        dsk_irq
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  logic   rr;       // last master served
  logic   irq_own;  // master that issued the most recent completed write
  logic   lock0;
  logic   lock1;

`ifdef DSK_ARB_LOCK_EN
  assign lock0 = m0_lock;
  assign lock1 = m1_lock;
`else
  assign lock0 = 1'b0;
  assign lock1 = 1'b0;
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr      <= 1'b1;
      irq_own <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_en && m1_en) state <= rr ? GNT0 : GNT1;
          else if (m0_en)     state <= GNT0;
          else if (m1_en)     state <= GNT1;
        end
        GNT0: begin
          if (!m0_en) begin
            state <= IDLE;
          end else if (!dsk_wt) begin
            rr <= 1'b0;
            if (m0_wr) irq_own <= 1'b0;
            state <= lock0 ? GNT0 : IDLE;
          end
        end
        GNT1: begin
          if (!m1_en) begin
            state <= IDLE;
          end else if (!dsk_wt) begin
            rr <= 1'b1;
            if (m1_wr) irq_own <= 1'b1;
            state <= lock1 ? GNT1 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request path is combinational so a granted master sees its own en the same cycle.
  assign dsk_en      = (state == GNT0) ? m0_en : ((state == GNT1) ? m1_en : 1'b0);
  assign dsk_wr      = (state == GNT1) ? m1_wr      : m0_wr;
  assign dsk_addr    = (state == GNT1) ? m1_addr    : m0_addr;
  assign dsk_data_in = (state == GNT1) ? m1_data_in : m0_data_in;

  assign m0_data_out = dsk_data_out;
  assign m1_data_out = dsk_data_out;

  assign m0_wt = m0_en & ~((state == GNT0) & ~dsk_wt);
  assign m1_wt = m1_en & ~((state == GNT1) & ~dsk_wt);

  assign m0_irq = dsk_irq & ~irq_own;
  assign m1_irq = dsk_irq &  irq_own;

endmodule

// File: tb/tb_dsk_arb.sv
// Directed self-checking bench for dsk_arb; expected grant order follows DSK_ARB_LOCK_EN.
module tb_dsk_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic        m0_en, m0_wr, m0_lock, m0_wt, m0_irq;
  logic [19:2] m0_addr;
  logic [31:0] m0_data_in, m0_data_out;
  logic        m1_en, m1_wr, m1_lock, m1_wt, m1_irq;
  logic [19:2] m1_addr;
  logic [31:0] m1_data_in, m1_data_out;
  logic        dsk_en, dsk_wr, dsk_wt, dsk_irq;
  logic [19:2] dsk_addr;
  logic [31:0] dsk_data_in, dsk_data_out;

  int n_cmp = 0;
  int n_bad = 0;
  int got_m[$];
  int got_c[$];
  bit seq_done;

  always #5 clk = ~clk;

  dsk_arb dut (
    .clk(clk), .reset(reset),
    .m0_en(m0_en), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_data_in(m0_data_in),
    .m0_lock(m0_lock), .m0_data_out(m0_data_out), .m0_wt(m0_wt), .m0_irq(m0_irq),
    .m1_en(m1_en), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_data_in(m1_data_in),
    .m1_lock(m1_lock), .m1_data_out(m1_data_out), .m1_wt(m1_wt), .m1_irq(m1_irq),
    .dsk_en(dsk_en), .dsk_wr(dsk_wr), .dsk_addr(dsk_addr), .dsk_data_in(dsk_data_in),
    .dsk_data_out(dsk_data_out), .dsk_wt(dsk_wt), .dsk_irq(dsk_irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives both masters as simple request generators and logs each completion.
  task automatic run_seq(input int n0, input int n1, input int d0,
                         input bit w0, input bit w1, input bit lk1);
    int rem0 = n0;
    int rem1 = n1;
    got_m.delete();
    got_c.delete();
    seq_done = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      m0_en = (rem0 > 0) && (cyc >= d0);
      m0_wr = w0; m0_addr = 18'h00100; m0_data_in = 32'h0000_00A0 + cyc;
      m1_en = (rem1 > 0);
      m1_wr = w1; m1_addr = 18'h00200; m1_data_in = 32'h0000_00B0 + cyc;
      m1_lock = lk1 && (rem1 > 1);
      dsk_wt = 1'b0;
      @(negedge clk);
      if (m0_en && !m0_wt) begin got_m.push_back(0); got_c.push_back(cyc); rem0--; end
      if (m1_en && !m1_wt) begin got_m.push_back(1); got_c.push_back(cyc); rem1--; end
      if (rem0 == 0 && rem1 == 0) begin seq_done = 1'b1; break; end
      step();
    end
    step();
    m0_en = 1'b0; m1_en = 1'b0; m1_lock = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; m1_en = 1'b1;
    step(); step();
    @(negedge clk);
    n_cmp++; if (dsk_en !== 1'b0) begin n_bad++; $display("FAIL rst_dsk_en got %b want 0", dsk_en); end
    n_cmp++; if (m1_wt !== 1'b1) begin n_bad++; $display("FAIL rst_m1_wt got %b want 1", m1_wt); end
    n_cmp++; if (m0_wt !== 1'b0) begin n_bad++; $display("FAIL rst_m0_wt got %b want 0", m0_wt); end
    step();
    reset = 1'b0; m1_en = 1'b0; dsk_irq = 1'b0;
    @(negedge clk);
    n_cmp++; if ({m0_irq, m1_irq} !== 2'b00) begin n_bad++; $display("FAIL rst_irq_low got %b want 00", {m0_irq, m1_irq}); end
    dsk_irq = 1'b1;
    #1;
    n_cmp++; if ({m0_irq, m1_irq} !== 2'b10) begin n_bad++; $display("FAIL rst_irq_route got %b want 10", {m0_irq, m1_irq}); end
    dsk_irq = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_read();
    m0_en = 1'b1; m0_wr = 1'b0; m0_addr = 18'h00010; dsk_data_out = 32'h1234_5678; dsk_wt = 1'b0;
    @(negedge clk);
    n_cmp++; if (m0_wt !== 1'b1) begin n_bad++; $display("FAIL rd_c0_wt got %b want 1", m0_wt); end
    n_cmp++; if (dsk_en !== 1'b0) begin n_bad++; $display("FAIL rd_c0_en got %b want 0", dsk_en); end
    step();
    @(negedge clk);
    n_cmp++; if (dsk_en !== 1'b1) begin n_bad++; $display("FAIL rd_c1_en got %b want 1", dsk_en); end
    n_cmp++; if (dsk_addr !== 18'h00010) begin n_bad++; $display("FAIL rd_addr got %h want 00010", dsk_addr); end
    n_cmp++; if (dsk_wr !== 1'b0) begin n_bad++; $display("FAIL rd_wr got %b want 0", dsk_wr); end
    n_cmp++; if (m0_wt !== 1'b0) begin n_bad++; $display("FAIL rd_c1_wt got %b want 0", m0_wt); end
    n_cmp++; if (m0_data_out !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_data got %h want 12345678", m0_data_out); end
    step();
    m0_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (dsk_en !== 1'b0) begin n_bad++; $display("FAIL rd_c2_en got %b want 0", dsk_en); end
    step();
    $display("test_read done");
  endtask

  task automatic test_fairness();
    int exp_c[2];
    exp_c = '{1, 3};
    reset = 1'b1; step(); reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      run_seq(1, 1, 0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (!seq_done) begin n_bad++; $display("FAIL fair_timeout pair %0d got stuck want done", p); end
      n_cmp++; if (got_m.size() !== 2) begin n_bad++; $display("FAIL fair_count pair %0d got %0d want 2", p, got_m.size()); end
      for (int i = 0; i < 2; i++) begin
        if (i < got_m.size()) begin
          n_cmp++; if (got_m[i] !== i) begin n_bad++; $display("FAIL fair_order pair %0d slot %0d got m%0d want m%0d", p, i, got_m[i], i); end
          n_cmp++; if (got_c[i] !== exp_c[i]) begin n_bad++; $display("FAIL fair_cycle pair %0d slot %0d got %0d want %0d", p, i, got_c[i], exp_c[i]); end
        end
      end
      $display("test_fairness pair %0d: %0d grants", p, got_m.size());
    end
  endtask

  task automatic test_write_wait_irq();
    m1_en = 1'b1; m1_wr = 1'b1; m1_addr = 18'h2A5A5; m1_data_in = 32'hCAFE_F00D;
    m0_en = 1'b0; dsk_wt = 1'b1; dsk_irq = 1'b0;
    @(negedge clk);
    n_cmp++; if (m1_wt !== 1'b1) begin n_bad++; $display("FAIL wr_c0_wt got %b want 1", m1_wt); end
    step();
    m0_en = 1'b1; m0_wr = 1'b0; m0_addr = 18'h00111;
    @(negedge clk);
    n_cmp++; if (dsk_en !== 1'b1) begin n_bad++; $display("FAIL wr_en got %b want 1", dsk_en); end
    n_cmp++; if (dsk_wr !== 1'b1) begin n_bad++; $display("FAIL wr_wr got %b want 1", dsk_wr); end
    n_cmp++; if (dsk_addr !== 18'h2A5A5) begin n_bad++; $display("FAIL wr_addr got %h want 2a5a5", dsk_addr); end
    n_cmp++; if (dsk_data_in !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL wr_data got %h want cafef00d", dsk_data_in); end
    for (int c = 1; c < 4; c++) begin
      if (c > 1) @(negedge clk);
      n_cmp++; if ({m1_wt, m0_wt} !== 2'b11) begin n_bad++; $display("FAIL wr_wait c%0d got m1/m0 wt %b want 11", c, {m1_wt, m0_wt}); end
      step();
    end
    dsk_wt = 1'b0;
    @(negedge clk);
    n_cmp++; if ({m1_wt, m0_wt} !== 2'b01) begin n_bad++; $display("FAIL wr_done got m1/m0 wt %b want 01", {m1_wt, m0_wt}); end
    step();
    m1_en = 1'b0; dsk_irq = 1'b1;
    @(negedge clk);
    n_cmp++; if ({m1_irq, m0_irq} !== 2'b10) begin n_bad++; $display("FAIL wr_irq got m1/m0 irq %b want 10", {m1_irq, m0_irq}); end
    n_cmp++; if (dsk_en !== 1'b0) begin n_bad++; $display("FAIL wr_idle_en got %b want 0", dsk_en); end
    step();
    @(negedge clk);
    n_cmp++; if (dsk_addr !== 18'h00111 || m0_wt !== 1'b0) begin n_bad++; $display("FAIL wr_m0_grant got addr %h wt %b want 00111 0", dsk_addr, m0_wt); end
    step();
    m0_en = 1'b0;
    @(negedge clk);
    n_cmp++; if ({m1_irq, m0_irq} !== 2'b10) begin n_bad++; $display("FAIL wr_irq_keep got %b want 10", {m1_irq, m0_irq}); end
    dsk_irq = 1'b0;
    step();
    $display("test_write_wait_irq done");
  endtask

  task automatic test_reset_mid();
    m0_en = 1'b1; m0_wr = 1'b1; m0_addr = 18'h00333; dsk_wt = 1'b1;
    step();
    @(negedge clk);
    n_cmp++; if (dsk_en !== 1'b1) begin n_bad++; $display("FAIL rm_gnt_en got %b want 1", dsk_en); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; dsk_irq = 1'b1;
    @(negedge clk);
    n_cmp++; if (dsk_en !== 1'b0) begin n_bad++; $display("FAIL rm_en got %b want 0", dsk_en); end
    n_cmp++; if (m0_wt !== 1'b1) begin n_bad++; $display("FAIL rm_wt got %b want 1", m0_wt); end
    n_cmp++; if ({m1_irq, m0_irq} !== 2'b01) begin n_bad++; $display("FAIL rm_irq_own got m1/m0 %b want 01", {m1_irq, m0_irq}); end
    step();
    dsk_irq = 1'b0; m0_en = 1'b0; dsk_wt = 1'b0;
    step();
    $display("test_reset_mid done");
  endtask

  task automatic test_lock_seq();
    int exp_m[6];
    int exp_c[6];
`ifdef DSK_ARB_LOCK_EN
    exp_m = '{1, 1, 1, 0, 0, 0};
    exp_c = '{1, 2, 3, 5, 7, 9};
`else
    exp_m = '{1, 0, 1, 0, 1, 0};
    exp_c = '{1, 3, 5, 7, 9, 11};
`endif
    run_seq(3, 3, 1, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (!seq_done) begin n_bad++; $display("FAIL seq_timeout got stuck want done"); end
    n_cmp++; if (got_m.size() !== 6) begin n_bad++; $display("FAIL seq_count got %0d want 6", got_m.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < got_m.size()) begin
        n_cmp++; if (got_m[i] !== exp_m[i]) begin n_bad++; $display("FAIL seq_order slot %0d got m%0d want m%0d", i, got_m[i], exp_m[i]); end
        n_cmp++; if (got_c[i] !== exp_c[i]) begin n_bad++; $display("FAIL seq_cycle slot %0d got %0d want %0d", i, got_c[i], exp_c[i]); end
      end
    end
    $display("test_lock_seq: %0d grants", got_m.size());
  endtask

  initial begin
    reset = 1'b1;
    m0_en = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_data_in = '0; m0_lock = 1'b0;
    m1_en = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_data_in = '0; m1_lock = 1'b0;
    dsk_data_out = '0; dsk_wt = 1'b0; dsk_irq = 1'b0;
    test_reset();
    test_read();
    test_fairness();
    test_write_wait_irq();
    test_reset_mid();
    test_lock_seq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
